// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer feeding an external round_enc datapath.
// Optional AES_LAST_KEY_OUT_EN exposes the round-10 key on last_key for decryption setup.
module aes_round_ctrl #(
  parameter int unsigned NR    = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic         rnd_last,
  output logic         rnd_vin,
  input  logic [127:0] rnd_state_out,
  input  logic         rnd_vout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
`ifdef AES_LAST_KEY_OUT_EN
  output logic [127:0] last_key,
`endif
  output logic         busy
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       state_q, state_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       ct_q, ct_d;
  logic               ov_q, ov_d;
  logic [127:0]       nk;
  logic [31:0]        t;
  logic               accept, final_rnd;

  // Byte 0 of the table sits in the top bits, so index from the MSB end.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] c);
    case (c)
      CNT_W'(1):  return 8'h01;
      CNT_W'(2):  return 8'h02;
      CNT_W'(3):  return 8'h04;
      CNT_W'(4):  return 8'h08;
      CNT_W'(5):  return 8'h10;
      CNT_W'(6):  return 8'h20;
      CNT_W'(7):  return 8'h40;
      CNT_W'(8):  return 8'h80;
      CNT_W'(9):  return 8'h1b;
      CNT_W'(10): return 8'h36;
      default:    return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w3)) ^ rcon, then the running XOR chain across w0..w3.
  always_comb begin
    t = {sbox(key_q[23:16]), sbox(key_q[15:8]), sbox(key_q[7:0]), sbox(key_q[31:24])}
        ^ {rcon(cnt_q), 24'h0};
    nk[127:96] = key_q[127:96] ^ t;
    nk[95:64]  = key_q[95:64] ^ nk[127:96];
    nk[63:32]  = key_q[63:32] ^ nk[95:64];
    nk[31:0]   = key_q[31:0] ^ nk[63:32];
  end

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    key_d     = key_q;
    ct_d      = ct_q;
    ov_d      = ov_q;
    accept    = 1'b0;
    final_rnd = 1'b0;
    case (fsm_q)
      StIdle: begin
        if (in_valid) begin
          accept  = 1'b1;
          fsm_d   = StRound;
          state_d = plaintext ^ key;
          key_d   = key;
          cnt_d   = CNT_W'(1);
        end
      end
      StRound: begin
        if (rnd_vout) begin
          if (cnt_q == CNT_W'(NR)) begin
            final_rnd = 1'b1;
            ct_d      = rnd_state_out;
            ov_d      = 1'b1;
            fsm_d     = StDone;
          end else begin
            state_d = rnd_state_out;
            key_d   = nk;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          ov_d  = 1'b0;
          cnt_d = '0;
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= StIdle;
      cnt_q   <= '0;
      state_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      ov_q    <= ov_d;
    end
  end

`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0] lk_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      lk_q <= '0;
    end else if (final_rnd) begin
      lk_q <= nk;
    end
  end

  assign last_key = lk_q;
`endif

  always_comb begin
    in_ready   = (fsm_q == StIdle);
    busy       = (fsm_q != StIdle);
    rnd_vin    = (fsm_q == StRound);
    rnd_last   = (fsm_q == StRound) && (cnt_q == CNT_W'(NR));
    rnd_state  = (fsm_q == StRound) ? state_q : '0;
    rnd_key    = (fsm_q == StRound) ? nk : '0;
    out_valid  = ov_q;
    ciphertext = ct_q;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl with a behavioural round_enc and AES-128 reference model.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic         rnd_last;
  logic         rnd_vin;
  logic [127:0] rnd_state_out;
  logic         rnd_vout;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0] last_key;
`endif

  typedef struct {
    logic [127:0] ct;
    logic [127:0] lk;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] sbox_t [256];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         out_acc_cyc = 0;
  int         exp_lat = 0;
  logic       ov_prev = 1'b0;
  logic       stall_dir, stall_rnd = 1'b0, rnd_mode;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_LK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_round_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .plaintext     (plaintext),
    .key           (key),
    .rnd_state     (rnd_state),
    .rnd_key       (rnd_key),
    .rnd_last      (rnd_last),
    .rnd_vin       (rnd_vin),
    .rnd_state_out (rnd_state_out),
    .rnd_vout      (rnd_vout),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ciphertext    (ciphertext),
`ifdef AES_LAST_KEY_OUT_EN
    .last_key      (last_key),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3;
        b[4*c+1] = x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3;
        b[4*c+2] = x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03);
        b[4*c+3] = gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  function automatic exp_t model(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc = 8'h01;
    logic [127:0] s;
    exp_t         e;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
            ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++)
      s = aes_round(s, {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, r == 10);
    e.ct = s;
    e.lk = {w[40], w[41], w[42], w[43]};
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural round_enc: combinational, with optional stall injection on vout.
  always @(rnd_state or rnd_key or rnd_last) rnd_state_out = aes_round(rnd_state, rnd_key, rnd_last);
  assign rnd_vout = rnd_vin & ~stall_dir & ~(rnd_mode & stall_rnd);
  always @(posedge clk) stall_rnd <= ($urandom_range(0, 3) == 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(plaintext, key));
      acc_cyc <= cyc + 1;
    end
    if (!rst && out_valid && out_ready) out_acc_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    ov_prev <= out_valid;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 128'(out_valid), 128'h0);
      end else begin
        chk("ciphertext", ciphertext, exp_q[0].ct);
`ifdef AES_LAST_KEY_OUT_EN
        chk("last_key", last_key, exp_q[0].lk);
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
      if (!ov_prev && exp_lat != 0) chk("latency", 128'(cyc - acc_cyc + 1), 128'(exp_lat));
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] k);
    logic got = 1'b0;
    in_valid  = 1'b1;
    plaintext = pt;
    key       = k;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 128'(in_ready), 128'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns at a negedge with out_valid high, or records a timeout.
  task automatic wait_out(input int budget);
    logic got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("out_valid_timeout", 128'(out_valid), 128'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] p1, k1, p2, k2;
    rst = 1'b1; in_valid = 1'b0; plaintext = '0; key = '0;
    out_ready = 1'b1; stall_dir = 1'b0; rnd_mode = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'h1);
    chk("rst_out_valid", 128'(out_valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_rnd_vin", 128'(rnd_vin), 128'h0);
    chk("rst_rnd_last", 128'(rnd_last), 128'h0);
    chk("rst_rnd_state", rnd_state, 128'h0);
    chk("rst_rnd_key", rnd_key, 128'h0);
    chk("rst_ciphertext", ciphertext, 128'h0);
`ifdef AES_LAST_KEY_OUT_EN
    chk("rst_last_key", last_key, 128'h0);
`endif
    @(posedge clk); #1;

    // FIPS-197 C.1
    exp_lat = 11;
    send(C1_PT, C1_KEY);
    wait_out(40);
    chk("c1_ct", ciphertext, C1_CT);
    @(posedge clk); #1;

    // FIPS-197 B, consumer holds off for 5 cycles while a new request waits
    out_ready = 1'b0;
    send(B_PT, B_KEY);
    wait_out(40);
    chk("b_ct", ciphertext, B_CT);
`ifdef AES_LAST_KEY_OUT_EN
    chk("b_last_key", last_key, B_LK);
`endif
    @(posedge clk); #1;
    p1 = {$urandom, $urandom, $urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; plaintext = p1; key = k1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", 128'(out_valid), 128'h1);
      chk("hold_in_ready", 128'(in_ready), 128'h0);
      chk("hold_ct", ciphertext, B_CT);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(p1, k1);
    chk("hold_accept_gap", 128'(acc_cyc - out_acc_cyc), 128'h1);
    wait_out(40);
    @(posedge clk); #1;

    // Three stall cycles during round 4
    exp_lat = 14;
    send(C1_PT, C1_KEY);
    repeat (3) @(posedge clk);
    #1 stall_dir = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall_dir = 1'b0;
    wait_out(40);
    chk("stall_ct", ciphertext, C1_CT);
    @(posedge clk); #1;

    // Abort in round 6
    exp_lat = 0;
    send(B_PT, B_KEY);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_out_valid", 128'(out_valid), 128'h0);
    chk("abort_in_ready", 128'(in_ready), 128'h1);
    chk("abort_busy", 128'(busy), 128'h0);
    @(posedge clk); #1;
    exp_lat = 11;
    send(C1_PT, C1_KEY);
    wait_out(40);
    chk("post_abort_ct", ciphertext, C1_CT);
    @(posedge clk); #1;

    // Back-to-back
    p1 = {$urandom, $urandom, $urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    send(p1, k1);
    send(p2, k2);
    chk("b2b_accept_gap", 128'(acc_cyc - out_acc_cyc), 128'h1);
    wait_out(40);
    @(posedge clk); #1;

    // Random traffic with random stalls and consumer back-pressure
    exp_lat = 0;
    rnd_mode = 1'b1;
    for (int n = 0; n < 20; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      wait_out(200);
      @(posedge clk); #1;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    rnd_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'h0);
    chk("final_out_valid", 128'(out_valid), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
